// File: rtl/vga_display_mem_arbiter.sv
// Shares one synchronous frame-buffer port between VGA scan-out (fixed 3-cycle
// hpos-to-pixel latency) and a FIFO-buffered pixel writer served only in blanking.
module vga_display_mem_arbiter #(
  parameter int unsigned POS_SIZE    = 9,
  parameter int unsigned FB_WIDTH    = 160,
  parameter int unsigned FB_HEIGHT   = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WQ_DEPTH    = 4
) (
  input  logic              i_pixel_clock,
  input  logic              i_reset,
  input  logic [POS_SIZE:0] i_hpos,
  input  logic [POS_SIZE:0] i_vpos,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid
);

  localparam int unsigned PTR_W   = $clog2(WQ_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned FB_SIZE = FB_WIDTH * FB_HEIGHT;
  localparam logic [POS_SIZE:0] POS_OFF = '1;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_FETCH = 2'd1,
    MODE_WRITE = 2'd2
  } mode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

  mode_e             r_mode;
  mode_e             w_mode_nxt;
  wq_entry_t         r_wq [WQ_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_fetch_d2;
  wq_entry_t         w_head;
  wq_entry_t         w_wr_entry;
  logic              w_active;
  logic              w_wq_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_head_in_range;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic              w_mem_we_nxt;

  assign w_active   = (i_hpos != POS_OFF) && (i_vpos != POS_OFF);
  assign w_wq_empty = (r_count == '0);
  assign o_wr_ready = i_reset && (r_count < CNT_W'(WQ_DEPTH));
  assign w_push     = i_wr_valid && o_wr_ready;

  assign w_head          = r_wq[r_rd_ptr];
  assign w_wr_entry      = '{addr: i_wr_addr, data: i_wr_data};
  assign w_head_in_range = (32'(w_head.addr) < FB_SIZE);

  // Downscaled raster position to linear frame-buffer address
  assign w_fetch_addr = ADDR_W'(((32'(i_vpos) >> SCALE_SHIFT) * 32'(FB_WIDTH))
                                + (32'(i_hpos) >> SCALE_SHIFT));

  // Mode register
  always_ff @(posedge i_pixel_clock) begin
    if (!i_reset) begin
      r_mode <= MODE_IDLE;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Fixed priority: display fetch beats queued writes
  always_comb begin
    w_mode_nxt = MODE_IDLE;
    if (w_active) begin
      w_mode_nxt = MODE_FETCH;
    end else if (!w_wq_empty) begin
      w_mode_nxt = MODE_WRITE;
    end
  end

  // Memory-port controls for the mode being entered
  always_comb begin
    w_mem_addr_nxt  = o_mem_addr;
    w_mem_wdata_nxt = o_mem_wdata;
    w_mem_we_nxt    = 1'b0;
    w_pop           = 1'b0;
    unique case (w_mode_nxt)
      MODE_FETCH: begin
        w_mem_addr_nxt = w_fetch_addr;
      end
      MODE_WRITE: begin
        w_pop = 1'b1;
        if (w_head_in_range) begin
          w_mem_addr_nxt  = w_head.addr;
          w_mem_wdata_nxt = w_head.data;
          w_mem_we_nxt    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_pixel_clock) begin
    if (!i_reset) begin
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
    end else begin
      o_mem_addr  <= w_mem_addr_nxt;
      o_mem_wdata <= w_mem_wdata_nxt;
      o_mem_we    <= w_mem_we_nxt;
    end
  end

  // r_mode is fetch stage 1; rdata arrives alongside stage 2
  always_ff @(posedge i_pixel_clock) begin
    if (!i_reset) begin
      r_fetch_d2  <= 1'b0;
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
    end else begin
      r_fetch_d2  <= (r_mode == MODE_FETCH);
      o_pix_valid <= r_fetch_d2;
      o_pix_data  <= r_fetch_d2 ? i_mem_rdata : '0;
    end
  end

  // Write-queue pointers and occupancy
  always_ff @(posedge i_pixel_clock) begin
    if (!i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_pixel_clock) begin
    if (w_push) begin
      r_wq[r_wr_ptr] <= w_wr_entry;
    end
  end

endmodule
